// File: rtl/disp_event_buffer.sv
// Trace buffer between the MIPS core and the seg7x16 driver: captures one record per
// CPU step into a small FIFO and replays each record for HOLD_CYCLES display clocks.
module disp_event_buffer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_step,
    input  logic                     reg_wr,
    input  logic [DATA_W-1:0]        reg_wdata,
    input  logic                     mem_wr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     live,
    input  logic                     freeze,
    output logic [DATA_W-1:0]        disp_data,
    output logic [1:0]               disp_kind,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [1:0]        KIND_PC   = 2'd0;
    localparam logic [1:0]        KIND_REG  = 2'd1;
    localparam logic [1:0]        KIND_MEM  = 2'd2;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef struct packed {
        logic [1:0]        kind;
        logic [DATA_W-1:0] data;
    } rec_t;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    rec_t              fifo_mem [DEPTH];
    rec_t              rec_c;
    rec_t              head_c;
    logic              pop_c;
    logic              push_c;
    logic              drop_c;

    // Record forming: reg write beats mem write beats plain PC
    always_comb begin
        rec_c.kind = KIND_PC;
        rec_c.data = pc;
        if (reg_wr) begin
            rec_c.kind = KIND_REG;
            rec_c.data = reg_wdata;
        end else if (mem_wr) begin
            rec_c.kind = KIND_MEM;
            rec_c.data = mem_wdata;
        end
    end

    assign head_c = fifo_mem[rd_ptr];

    // Replay FSM; live or freeze stall both the hold counter and pops
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pop_c     = 1'b0;
        if (!live && !freeze) begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        pop_c     = 1'b1;
                        hold_nxt  = '0;
                        state_nxt = SHOW;
                    end
                end
                SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (fifo_count != '0) begin
                            pop_c    = 1'b1;
                            hold_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        hold_nxt = HOLD_W'(hold_cnt + 1'b1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the same cycle frees a slot
    assign push_c = cpu_step && ((fifo_count != CNT_FULL) || pop_c);
    assign drop_c = cpu_step && !push_c;

    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            fifo_mem[wr_ptr] <= rec_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            disp_data  <= '0;
            disp_kind  <= KIND_PC;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (push_c) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop_c) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_count <= CNT_W'(fifo_count + 1'b1);
                2'b01:   fifo_count <= CNT_W'(fifo_count - 1'b1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop_c) begin
                overflow <= 1'b1;
            end
            if (live) begin
                disp_data <= pc;
                disp_kind <= KIND_PC;
            end else if (pop_c) begin
                disp_data <= head_c.data;
                disp_kind <= head_c.kind;
            end
        end
    end

endmodule

// File: tb/tb_disp_event_buffer.sv
// Directed bench for disp_event_buffer with DEPTH=4, HOLD_CYCLES=4.
module tb_disp_event_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              cpu_step;
    logic              reg_wr;
    logic [DATA_W-1:0] reg_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] pc;
    logic              live;
    logic              freeze;
    logic [DATA_W-1:0] disp_data;
    logic [1:0]        disp_kind;
    logic [2:0]        fifo_count;
    logic              overflow;

    int n_cmp;
    int n_err;

    disp_event_buffer #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .DATA_W     (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_step  (cpu_step),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .pc        (pc),
        .live      (live),
        .freeze    (freeze),
        .disp_data (disp_data),
        .disp_kind (disp_kind),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_step = 1'b1; reg_wr = 1'b1; reg_wdata = 32'h1234;
        tick();
        cpu_step = 1'b0;
        tick();
        n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want %h", disp_data, 32'h0); end
        n_cmp++; if (disp_kind !== 2'd0) begin n_err++; $display("FAIL reset_kind: got %0d want 0", disp_kind); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        rst = 1'b0; reg_wr = 1'b0;
        tick(3);
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_nopush_count: got %0d want 0", fifo_count); end
        n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL reset_nopush_data: got %h want 0", disp_data); end
    endtask

    task automatic test_single();
        cpu_step = 1'b1; reg_wr = 1'b1; reg_wdata = 32'h5;
        tick();
        cpu_step = 1'b0; reg_wr = 1'b0;
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL single_count_e0: got %0d want 1", fifo_count); end
        n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL single_early: got %h want 0", disp_data); end
        tick();
        n_cmp++; if (disp_data !== 32'h5) begin n_err++; $display("FAIL single_data: got %h want 5", disp_data); end
        n_cmp++; if (disp_kind !== 2'd1) begin n_err++; $display("FAIL single_kind: got %0d want 1", disp_kind); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL single_count_e1: got %0d want 0", fifo_count); end
        tick(3);
        n_cmp++; if (disp_data !== 32'h5) begin n_err++; $display("FAIL single_hold: got %h want 5", disp_data); end
        tick(16);
        n_cmp++; if (disp_data !== 32'h5) begin n_err++; $display("FAIL single_idle_data: got %h want 5", disp_data); end
        n_cmp++; if (disp_kind !== 2'd1) begin n_err++; $display("FAIL single_idle_kind: got %0d want 1", disp_kind); end
    endtask

    task automatic test_priority();
        cpu_step = 1'b1; reg_wr = 1'b1; mem_wr = 1'b1; reg_wdata = 32'hA; mem_wdata = 32'hB;
        tick();
        reg_wr = 1'b0;
        tick();
        cpu_step = 1'b0; mem_wr = 1'b0;
        n_cmp++; if (disp_data !== 32'hA) begin n_err++; $display("FAIL prio_data: got %h want a", disp_data); end
        n_cmp++; if (disp_kind !== 2'd1) begin n_err++; $display("FAIL prio_kind: got %0d want 1", disp_kind); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL prio_count: got %0d want 1", fifo_count); end
        tick(3);
        n_cmp++; if (disp_data !== 32'hA) begin n_err++; $display("FAIL prio_hold: got %h want a", disp_data); end
        tick();
        n_cmp++; if (disp_data !== 32'hB) begin n_err++; $display("FAIL prio_mem_data: got %h want b", disp_data); end
        n_cmp++; if (disp_kind !== 2'd2) begin n_err++; $display("FAIL prio_mem_kind: got %0d want 2", disp_kind); end
        tick(6);
    endtask

    // Seven back-to-back steps: the sixth lands on a pop (accepted), the seventh is dropped
    task automatic test_overflow();
        logic [DATA_W-1:0] exp_vals [4];
        exp_vals[0] = 32'h8; exp_vals[1] = 32'hC; exp_vals[2] = 32'h10; exp_vals[3] = 32'h14;
        for (int i = 0; i < 7; i++) begin
            cpu_step = 1'b1; pc = DATA_W'(4 * i);
            tick();
            if (i == 4) begin
                n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_full_count: got %0d want 4", fifo_count); end
                n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL ovf_first: got %h want 0", disp_data); end
                n_cmp++; if (disp_kind !== 2'd0) begin n_err++; $display("FAIL ovf_first_kind: got %0d want 0", disp_kind); end
            end
            if (i == 5) begin
                n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fullpop_count: got %0d want 4", fifo_count); end
                n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
                n_cmp++; if (disp_data !== 32'h4) begin n_err++; $display("FAIL fullpop_data: got %h want 4", disp_data); end
            end
            if (i == 6) begin
                n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
                n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
            end
        end
        cpu_step = 1'b0; pc = '0;
        tick(2);
        n_cmp++; if (disp_data !== 32'h4) begin n_err++; $display("FAIL ovf_hold4: got %h want 4", disp_data); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (disp_data !== exp_vals[k]) begin n_err++; $display("FAIL replay_%0d: got %h want %h", k, disp_data, exp_vals[k]); end
            n_cmp++; if (fifo_count !== 3'(3 - k)) begin n_err++; $display("FAIL replay_cnt_%0d: got %0d want %0d", k, fifo_count, 3 - k); end
            tick(3);
            n_cmp++; if (disp_data !== exp_vals[k]) begin n_err++; $display("FAIL replay_hold_%0d: got %h want %h", k, disp_data, exp_vals[k]); end
        end
        tick(4);
        n_cmp++; if (disp_data !== 32'h14) begin n_err++; $display("FAIL ovf_idle_data: got %h want 14", disp_data); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_freeze();
        cpu_step = 1'b1; reg_wr = 1'b1; reg_wdata = 32'h77;
        tick();
        cpu_step = 1'b0;
        tick();
        n_cmp++; if (disp_data !== 32'h77) begin n_err++; $display("FAIL frz_start: got %h want 77", disp_data); end
        tick();
        freeze = 1'b1; cpu_step = 1'b1; reg_wdata = 32'h88;
        tick();
        cpu_step = 1'b0; reg_wr = 1'b0;
        tick(9);
        n_cmp++; if (disp_data !== 32'h77) begin n_err++; $display("FAIL frz_data: got %h want 77", disp_data); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL frz_capture: got %0d want 1", fifo_count); end
        freeze = 1'b0;
        tick(2);
        n_cmp++; if (disp_data !== 32'h77) begin n_err++; $display("FAIL frz_resume_hold: got %h want 77", disp_data); end
        tick();
        n_cmp++; if (disp_data !== 32'h88) begin n_err++; $display("FAIL frz_resume_pop: got %h want 88", disp_data); end
        n_cmp++; if (disp_kind !== 2'd1) begin n_err++; $display("FAIL frz_resume_kind: got %0d want 1", disp_kind); end
    endtask

    task automatic test_live();
        live = 1'b1; pc = 32'h3000; cpu_step = 1'b1; reg_wr = 1'b1; reg_wdata = 32'h99;
        tick();
        cpu_step = 1'b0; reg_wr = 1'b0;
        n_cmp++; if (disp_data !== 32'h3000) begin n_err++; $display("FAIL live_data: got %h want 3000", disp_data); end
        n_cmp++; if (disp_kind !== 2'd0) begin n_err++; $display("FAIL live_kind: got %0d want 0", disp_kind); end
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL live_capture: got %0d want 1", fifo_count); end
        pc = 32'h3004;
        tick();
        n_cmp++; if (disp_data !== 32'h3004) begin n_err++; $display("FAIL live_track: got %h want 3004", disp_data); end
        tick();
        live = 1'b0; pc = '0;
        tick(3);
        n_cmp++; if (disp_data !== 32'h3004) begin n_err++; $display("FAIL live_exit_hold: got %h want 3004", disp_data); end
        tick();
        n_cmp++; if (disp_data !== 32'h99) begin n_err++; $display("FAIL live_exit_pop: got %h want 99", disp_data); end
        n_cmp++; if (disp_kind !== 2'd1) begin n_err++; $display("FAIL live_exit_kind: got %0d want 1", disp_kind); end
    endtask

    task automatic test_mid_reset();
        cpu_step = 1'b1; reg_wr = 1'b1; reg_wdata = 32'hAA;
        tick();
        cpu_step = 1'b0; reg_wr = 1'b0;
        n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL mrst_pre_count: got %0d want 1", fifo_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL mrst_count: got %0d want 0", fifo_count); end
        n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL mrst_data: got %h want 0", disp_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mrst_ovf: got %b want 0", overflow); end
        tick(6);
        n_cmp++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL mrst_discard: got %h want 0", disp_data); end
        cpu_step = 1'b1; mem_wr = 1'b1; mem_wdata = 32'h5;
        tick();
        cpu_step = 1'b0; mem_wr = 1'b0;
        tick();
        n_cmp++; if (disp_data !== 32'h5) begin n_err++; $display("FAIL mrst_after_data: got %h want 5", disp_data); end
        n_cmp++; if (disp_kind !== 2'd2) begin n_err++; $display("FAIL mrst_after_kind: got %0d want 2", disp_kind); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; cpu_step = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
        mem_wr = 1'b0; mem_wdata = '0; pc = '0; live = 1'b0; freeze = 1'b0;
        #1;
        test_reset();
        test_single();
        test_priority();
        test_overflow();
        test_freeze();
        test_live();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
